// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the memory access unit
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_HI   = 4'b1100;
   localparam logic [3:0] BE_LO   = 4'b0011;
   localparam logic [3:0] BE_L3   = 4'b1000;
   localparam logic [3:0] BE_L2   = 4'b0100;
   localparam logic [3:0] BE_L1   = 4'b0010;
   localparam logic [3:0] BE_L0   = 4'b0001;

   localparam int ACK_TIMEOUT_DEF = 255;

   // Load shaping captured at access start, replayed when read data returns.
   typedef struct packed {
      logic [1:0] addr_lo;
      logic       is_half;
      logic       is_byte;
      logic       sign;
   } ld_fmt_t;

endpackage

// File: rtl/mem_lane_format.sv
// rtl/mem_lane_format.sv - store lane replication / byte enables and load lane extraction
module mem_lane_format
   import mem_access_unit_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [1:0]  st_addr_lo,
   input  logic        st_half,
   input  logic        st_byte,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  ld_fmt_t     ld_fmt,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [1:0]  st_lane;
   logic [1:0]  ld_lane;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   always_comb begin
      // Physical lane index; for halves, lane[1] selects the upper 16 bits.
      st_lane = BIG_ENDIAN ? ~st_addr_lo : st_addr_lo;
      ld_lane = BIG_ENDIAN ? ~ld_fmt.addr_lo : ld_fmt.addr_lo;

      st_be    = BE_WORD;
      st_wdata = st_data;
      if (st_byte) begin
         st_wdata = {4{st_data[7:0]}};
         case (st_lane)
            2'd3:    st_be = BE_L3;
            2'd2:    st_be = BE_L2;
            2'd1:    st_be = BE_L1;
            default: st_be = BE_L0;
         endcase
      end else if (st_half) begin
         st_wdata = {2{st_data[15:0]}};
         st_be    = st_lane[1] ? BE_HI : BE_LO;
      end

      ld_b = ld_rdata[{ld_lane, 3'b000} +: 8];
      ld_h = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];
      if (ld_fmt.is_byte)
         ld_data = {{24{ld_fmt.sign & ld_b[7]}}, ld_b};
      else if (ld_fmt.is_half)
         ld_data = {{16{ld_fmt.sign & ld_h[15]}}, ld_h};
      else
         ld_data = ld_rdata;
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data bus sequencer with alignment checks, LL/SC link and ack timeout
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter bit BIG_ENDIAN  = 1'b1,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Valid,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemHalf,
   input  logic        MemByte,
   input  logic        MemSignExtend,
   input  logic        LLSC,
   input  logic        Eret,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic        DBus_Req,
   output logic        DBus_We,
   output logic [3:0]  DBus_Be,
   output logic [29:0] DBus_Addr,
   output logic [31:0] DBus_WData,
   input  logic        DBus_Ack,
   input  logic [31:0] DBus_RData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AddrErrL,
   output logic        AddrErrS,
   output logic        BusErr
);

   localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   state_t         state_q, state_d;
   logic           req_q, req_d;
   logic           we_q, we_d;
   logic [3:0]     be_q, be_d;
   logic [29:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           buserr_q, buserr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ll_bit_q, ll_bit_d;
   logic [29:0]    ll_addr_q, ll_addr_d;
   ld_fmt_t        fmt_q, fmt_d;
   logic           sc_q, sc_d;
   logic           ll_q, ll_d;

   logic        misaligned;
   logic        is_sc;
   logic        link_hit;
   logic        access;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   mem_lane_format #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
      .st_addr_lo (Address[1:0]),
      .st_half    (MemHalf),
      .st_byte    (MemByte),
      .st_data    (WriteData),
      .st_be      (st_be),
      .st_wdata   (st_wdata),
      .ld_fmt     (fmt_q),
      .ld_rdata   (DBus_RData),
      .ld_data    (ld_data)
   );

   always_comb begin
      misaligned = MemByte ? 1'b0 : (MemHalf ? Address[0] : |Address[1:0]);
      is_sc      = LLSC & MemWrite;
      link_hit   = ll_bit_q & (ll_addr_q == Address[31:2]);
      access     = Valid & (MemRead | MemWrite) & ~misaligned & (~is_sc | link_hit);
   end

   assign AddrErrS   = Valid & MemWrite & misaligned;
   assign AddrErrL   = Valid & MemRead & ~MemWrite & misaligned;
   assign Stall      = ~reset & (((state_q == ST_IDLE) & access) | (state_q == ST_REQ));
   assign DBus_Req   = req_q;
   assign DBus_We    = we_q;
   assign DBus_Be    = be_q;
   assign DBus_Addr  = addr_q;
   assign DBus_WData = wdata_q;
   assign ReadData   = rdata_q;
   assign BusErr     = buserr_q;

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      buserr_d  = 1'b0;
      cnt_d     = cnt_q;
      ll_bit_d  = ll_bit_q;
      ll_addr_d = ll_addr_q;
      fmt_d     = fmt_q;
      sc_d      = sc_q;
      ll_d      = ll_q;

      case (state_q)
         ST_IDLE: begin
            rdata_d = 32'd0;
            if (access) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               we_d    = MemWrite;
               be_d    = st_be;
               addr_d  = Address[31:2];
               wdata_d = st_wdata;
               fmt_d   = '{addr_lo: Address[1:0], is_half: MemHalf,
                           is_byte: MemByte, sign: MemSignExtend};
               sc_d    = is_sc;
               ll_d    = LLSC & ~MemWrite;
               cnt_d   = '0;
            end
         end
         ST_REQ: begin
            if (DBus_Ack) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = BE_NONE;
               cnt_d   = '0;
               rdata_d = sc_q ? 32'd1 : (we_q ? 32'd0 : ld_data);
               if (ll_q) begin
                  ll_bit_d  = 1'b1;
                  ll_addr_d = addr_q;
               end
               if (sc_q)
                  ll_bit_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = ST_DONE;
               req_d    = 1'b0;
               we_d     = 1'b0;
               be_d     = BE_NONE;
               cnt_d    = '0;
               rdata_d  = 32'd0;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            rdata_d = 32'd0;
            cnt_d   = '0;
         end
      endcase

      // An exception return always breaks the link, even against an LL finishing now.
      if (Eret)
         ll_bit_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         be_q      <= BE_NONE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         buserr_q  <= 1'b0;
         cnt_q     <= '0;
         ll_bit_q  <= 1'b0;
         ll_addr_q <= '0;
         fmt_q     <= '0;
         sc_q      <= 1'b0;
         ll_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         buserr_q  <= buserr_d;
         cnt_q     <= cnt_d;
         ll_bit_q  <= ll_bit_d;
         ll_addr_q <= ll_addr_d;
         fmt_q     <= fmt_d;
         sc_q      <= sc_d;
         ll_q      <= ll_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        Valid, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC, Eret;
   logic [31:0] Address, WriteData;
   logic        DBus_Req, DBus_We;
   logic [3:0]  DBus_Be;
   logic [29:0] DBus_Addr;
   logic [31:0] DBus_WData;
   logic        DBus_Ack;
   logic [31:0] DBus_RData;
   logic [31:0] ReadData;
   logic        Stall, AddrErrL, AddrErrS, BusErr;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;

   always #5 clock = ~clock;

   mem_access_unit dut (
      .clock(clock), .reset(reset), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemHalf(MemHalf), .MemByte(MemByte), .MemSignExtend(MemSignExtend), .LLSC(LLSC),
      .Eret(Eret), .Address(Address), .WriteData(WriteData), .DBus_Req(DBus_Req),
      .DBus_We(DBus_We), .DBus_Be(DBus_Be), .DBus_Addr(DBus_Addr), .DBus_WData(DBus_WData),
      .DBus_Ack(DBus_Ack), .DBus_RData(DBus_RData), .ReadData(ReadData), .Stall(Stall),
      .AddrErrL(AddrErrL), .AddrErrS(AddrErrS), .BusErr(BusErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic op(input logic rd, input logic wr, input logic half, input logic byt,
                     input logic sx, input logic llsc, input logic [31:0] addr,
                     input logic [31:0] wd);
      Valid = 1'b1; MemRead = rd; MemWrite = wr; MemHalf = half; MemByte = byt;
      MemSignExtend = sx; LLSC = llsc; Address = addr; WriteData = wd;
   endtask

   task automatic idle_in();
      Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemHalf = 1'b0; MemByte = 1'b0;
      MemSignExtend = 1'b0; LLSC = 1'b0; Address = 32'd0; WriteData = 32'd0;
      DBus_Ack = 1'b0;
   endtask

   initial begin
      idle_in();
      Eret = 1'b0; DBus_RData = 32'd0;
      reset = 1'b1;
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'd0);
      step(); step();
      chk("rst_stall", Stall, 1'b0);
      chk("rst_req", DBus_Req, 1'b0);
      chk("rst_be", DBus_Be, 4'b0000);
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_buserr", BusErr, 1'b0);
      idle_in();
      reset = 1'b0;
      step();

      // LB signed at 0x1003, ack in first REQ cycle (ack in IDLE ignored)
      op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1003, 32'd0);
      DBus_Ack = 1'b1; DBus_RData = 32'h1122_33F4;
      settle();
      chk("lb_stall_t", Stall, 1'b1);
      chk("lb_req_t", DBus_Req, 1'b0);
      step();
      chk("lb_req_t1", DBus_Req, 1'b1);
      chk("lb_be", DBus_Be, 4'b0001);
      chk("lb_addr", DBus_Addr, 30'h400);
      chk("lb_we", DBus_We, 1'b0);
      step();
      chk("lb_stall_t2", Stall, 1'b0);
      chk("lb_rdata", ReadData, 32'hFFFF_FFF4);
      idle_in();
      step();
      chk("lb_rdata_clr", ReadData, 32'd0);

      // LBU at 0x1001 with delayed ack
      op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1001, 32'd0);
      DBus_RData = 32'h11A2_3344;
      step();
      chk("lbu_be", DBus_Be, 4'b0100);
      step();
      chk("lbu_req_hold", DBus_Req, 1'b1);
      chk("lbu_stall_hold", Stall, 1'b1);
      chk("lbu_addr_hold", DBus_Addr, 30'h400);
      DBus_Ack = 1'b1;
      step();
      chk("lbu_rdata", ReadData, 32'h0000_00A2);
      idle_in();
      step();

      // SH at 0x2002
      op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2002, 32'h0000_ABCD);
      DBus_Ack = 1'b1;
      step();
      chk("sh_be", DBus_Be, 4'b0011);
      chk("sh_wdata", DBus_WData, 32'hABCD_ABCD);
      chk("sh_we", DBus_We, 1'b1);
      chk("sh_addr", DBus_Addr, 30'h800);
      step();
      chk("sh_stall", Stall, 1'b0);
      idle_in();
      step();

      // LH signed at 0x2000 (upper half)
      op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'd0);
      DBus_Ack = 1'b1; DBus_RData = 32'h8001_1234;
      step();
      chk("lh_be", DBus_Be, 4'b1100);
      step();
      chk("lh_rdata", ReadData, 32'hFFFF_8001);
      idle_in();
      step();

      // SB at 0x5001: replicated byte
      op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_5001, 32'h1234_5677);
      DBus_Ack = 1'b1;
      step();
      chk("sb_be", DBus_Be, 4'b0100);
      chk("sb_wdata", DBus_WData, 32'h7777_7777);
      step();
      idle_in();
      step();

      // MemRead and MemWrite both set: word write
      op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_5004, 32'hDEAD_BEEF);
      DBus_Ack = 1'b1;
      step();
      chk("rw_we", DBus_We, 1'b1);
      chk("rw_be", DBus_Be, 4'b1111);
      chk("rw_wdata", DBus_WData, 32'hDEAD_BEEF);
      step();
      idle_in();
      step();

      // Misaligned LW and SH
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3001, 32'd0);
      settle();
      chk("lw_mis_err", AddrErrL, 1'b1);
      chk("lw_mis_stall", Stall, 1'b0);
      step();
      chk("lw_mis_req", DBus_Req, 1'b0);
      op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3001, 32'd0);
      settle();
      chk("sh_mis_err", AddrErrS, 1'b1);
      chk("sh_mis_errl", AddrErrL, 1'b0);
      step();
      chk("sh_mis_req", DBus_Req, 1'b0);
      idle_in();
      step();

      // LL then SC success then SC failure
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'd0);
      DBus_Ack = 1'b1; DBus_RData = 32'h1234_5678;
      step(); step();
      chk("ll_rdata", ReadData, 32'h1234_5678);
      idle_in();
      step();
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0055);
      DBus_Ack = 1'b1;
      settle();
      chk("sc1_stall", Stall, 1'b1);
      step();
      chk("sc1_req", DBus_Req, 1'b1);
      chk("sc1_we", DBus_We, 1'b1);
      chk("sc1_wdata", DBus_WData, 32'h0000_0055);
      step();
      chk("sc1_rdata", ReadData, 32'd1);
      idle_in();
      step();
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0066);
      settle();
      chk("sc2_stall", Stall, 1'b0);
      chk("sc2_rdata", ReadData, 32'd0);
      step();
      chk("sc2_req", DBus_Req, 1'b0);
      idle_in();
      step();

      // LL completing while Eret is high leaves no link
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'd0);
      DBus_Ack = 1'b1; Eret = 1'b1;
      step(); step();
      Eret = 1'b0;
      idle_in();
      step();
      op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0077);
      settle();
      chk("sc_eret_stall", Stall, 1'b0);
      step();
      chk("sc_eret_req", DBus_Req, 1'b0);
      idle_in();
      step();

      // Ack timeout
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_6000, 32'd0);
      DBus_RData = 32'hCAFE_F00D;
      step();
      cyc = 0;
      while (DBus_Req === 1'b1 && cyc < 400) begin
         cyc++;
         step();
      end
      chk("tmo_req_cycles", cyc, 255);
      chk("tmo_buserr", BusErr, 1'b1);
      chk("tmo_rdata", ReadData, 32'd0);
      chk("tmo_stall", Stall, 1'b0);
      idle_in();
      step();
      chk("tmo_buserr_pulse", BusErr, 1'b0);

      // Reset while in REQ
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'd0);
      step(); step();
      chk("mid_req_before", DBus_Req, 1'b1);
      reset = 1'b1;
      settle();
      chk("mid_rst_stall", Stall, 1'b0);
      step();
      chk("mid_rst_req", DBus_Req, 1'b0);
      chk("mid_rst_be", DBus_Be, 4'b0000);
      idle_in();
      reset = 1'b0;
      step();
      chk("post_rst_stall", Stall, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter BIG_ENDIAN, default 1, byte-lane order: 1 = big-endian (addr[1:0]=00 is lane 3, bits 31:24); 0 = little-endian.
REQ-002 Parameter ACK_TIMEOUT, default 255, number of REQ-state cycles without Ack before a bus error is flagged.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Valid  in  1  MEM-stage instruction valid.
REQ-006 MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC  in  1 each  control bits produced by the ID-stage decoder.
REQ-007 Eret  in  1  clears the link bit.
REQ-008 Address  in  32  effective address from the ALU.
REQ-009 WriteData  in  32  store data, right-justified.
REQ-010 DBus_Req  out  1; DBus_We  out  1; DBus_Be  out  4; DBus_Addr  out  30 (word address); DBus_WData  out  32.
REQ-011 DBus_Ack  in  1; DBus_RData  in  32.
REQ-012 ReadData  out  32  load result, or SC status; valid in the cycle Stall falls.
REQ-013 Stall  out  1  freezes the pipeline while an access is outstanding.
REQ-014 AddrErrL, AddrErrS  out  1 each  misaligned load / store.
REQ-015 BusErr  out  1  one-cycle pulse on timeout.

Function
REQ-016 FSM states: IDLE, REQ, DONE; reset state is IDLE.
REQ-017 Access = Valid & (MemRead | MemWrite) & aligned; for SC, also link hit.
REQ-018 Aligned: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
REQ-019 IDLE with access present: Stall=1 combinationally; latch Be/Addr/WData/We; next state REQ.
REQ-020 REQ: DBus_Req=1 and all bus outputs held stable until the DBus_Ack cycle; on Ack, capture the formatted RData and go to DONE.
REQ-021 DONE: Stall=0 and ReadData valid for exactly one cycle; next state IDLE; a new access is not accepted in DONE.
REQ-022 Minimum latency: access seen at cycle t, DBus_Req at t+1; with Ack at t+1, Stall=0 at t+2.
REQ-023 Byte enables (big-endian): byte gives 1000/0100/0010/0001 for addr[1:0]=00/01/10/11; half gives 1100/0011 for addr[1]=0/1; word gives 1111.
REQ-024 Store data is replicated: byte across all four lanes, half across both halves.
REQ-025 Load formatting: select the addressed lane(s), right-justify, then sign-extend if MemSignExtend else zero-extend.
REQ-026 Misaligned access with Valid: matching AddrErr asserted combinationally, no bus cycle, Stall=0.
REQ-027 LL: on completion set LLbit=1 and LLAddr=addr[31:2].
REQ-028 SC with LLbit=1 and matching LLAddr: perform the store; on completion ReadData=1 and LLbit cleared.
REQ-029 SC otherwise: no bus cycle, Stall=0, ReadData=0.
REQ-030 Eret clears LLbit on the next edge; Eret wins over a simultaneous LL completion.
REQ-031 Timeout: a counter of REQ cycles reaching ACK_TIMEOUT pulses BusErr, drops DBus_Req, and goes to DONE with ReadData=0.
REQ-032 DBus_Ack outside REQ is ignored.
REQ-033 MemRead and MemWrite both set is treated as a write.
REQ-034 LWL/LWR merge is outside this block; these instructions are treated as word loads.

Reset
REQ-035 reset forces, on the same edge: IDLE, DBus_Req=0, DBus_We=0, DBus_Be=0, LLbit=0, counter=0, ReadData=0, BusErr=0; this applies even mid-REQ.
REQ-036 Stall=0 while reset is high.

Structure
REQ-037 A shared package holds the FSM state enum, the byte-enable constants, and the ACK_TIMEOUT default.
REQ-038 One sub-module, mem_lane_format (store replication and load extraction/extension), is purely combinational and instantiated once.

Verification
REQ-039 LB at 0x1003, RData=0x112233F4, Ack at t+1 -> Be=0001, ReadData=0xFFFFFFF4, Stall low at t+2.
REQ-040 SH at 0x2002 with WData=0x0000ABCD -> Be=0011, DBus_WData=0xABCDABCD, We=1.
REQ-041 LW at 0x3001 -> AddrErrL=1, DBus_Req never high, Stall=0.
REQ-042 LL at 0x4000 then SC at 0x4000 -> bus write occurs, ReadData=1; a second SC -> no bus cycle, ReadData=0.
REQ-043 LW with Ack withheld for 255 cycles -> BusErr pulse, DONE, ReadData=0; reset asserted in REQ instead -> DBus_Req=0 on the next edge.
